// File: rtl/sprite_compositor.sv
`default_nettype none
// ============================================================================
// Module   : sprite_compositor
// Brief    : Per-byte multi-sprite pixel compositor with a sync texture ROM
//            port and an optional dino/obstacle collision flag (SPRITE_COLLIDE_EN).
// Revision : 1.0 - initial release
// ============================================================================
module sprite_compositor #(
    parameter int         NUM_SPR = 3,
    parameter int         COLS_W  = 4,
    parameter int         ROWS_W  = 6,
    parameter int         TEX_AW  = 16,
    parameter logic [7:0] BG_BYTE = 8'h00
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic                          req,
    input  logic [COLS_W+ROWS_W-1:0]      addrD,
    output logic                          busy,
    output logic                          done,
    output logic [7:0]                    dataD,
    output logic [TEX_AW-1:0]             addrT,
    input  logic [7:0]                    dataT,
    input  logic [NUM_SPR-1:0]            spr_en,
    input  logic [NUM_SPR*(COLS_W+3)-1:0] spr_x,
    input  logic [NUM_SPR*ROWS_W-1:0]     spr_y,
    input  logic [NUM_SPR*2-1:0]          spr_wb,
    input  logic [NUM_SPR*ROWS_W-1:0]     spr_h,
    input  logic [NUM_SPR*TEX_AW-1:0]     spr_base,
    input  logic                          invert,
    input  logic                          clr_collide,
    output logic                          collide
);
    localparam int XW = COLS_W + 3;
    localparam int EW = XW + 2;
    localparam int LW = COLS_W + 2;
    localparam int KW = (NUM_SPR > 1) ? $clog2(NUM_SPR) : 1;
    localparam logic [KW-1:0] C_LAST = KW'(NUM_SPR - 1);

    typedef enum logic [2:0] {IDLE, CHECK, FETCH_LO, FETCH_HI, MERGE, DONE} state_t;
    state_t r_state, w_next;

    logic [COLS_W+ROWS_W-1:0] r_addr_d;
    logic [NUM_SPR-1:0]       r_en;
    logic [XW-1:0]            r_x    [NUM_SPR];
    logic [ROWS_W-1:0]        r_y    [NUM_SPR];
    logic [1:0]               r_wb   [NUM_SPR];
    logic [ROWS_W-1:0]        r_h    [NUM_SPR];
    logic [TEX_AW-1:0]        r_base [NUM_SPR];
    logic                     r_inv;
    logic [KW-1:0]            r_k;
    logic [7:0]               r_acc;
    logic [7:0]               r_blo;

    logic [ROWS_W-1:0] w_y, w_r;
    logic [ROWS_W+1:0] w_ye, w_sy, w_top;
    logic [EW-1:0]     w_px, w_sx, w_d;
    logic [2:0]        w_wbn;
    logic [LW-1:0]     w_lo, w_hi;
    logic              w_hit, w_lo_ok, w_hi_ok, w_last;
    logic [ROWS_W+2:0] w_rw;
    logic [TEX_AW-1:0] w_addr_lo;
    logic [15:0]       w_pair;
    logic [7:0]        w_bits;

    // All compares run 2 bits wider than the operands so edge sprites never wrap.
    always_comb begin
        w_y       = ~r_addr_d[ROWS_W-1:0];
        w_ye      = {2'b00, w_y};
        w_sy      = {2'b00, r_y[r_k]};
        w_top     = w_sy + {2'b00, r_h[r_k]};
        w_wbn     = {1'b0, r_wb[r_k]} + 3'd1;
        w_px      = {2'b00, r_addr_d[COLS_W+ROWS_W-1:ROWS_W], 3'b000};
        w_sx      = {2'b00, r_x[r_k]};
        w_hit     = r_en[r_k] && (w_ye >= w_sy) && (w_ye < w_top)
                 && (w_px + EW'(7) >= w_sx)
                 && (w_px < w_sx + {{(EW-6){1'b0}}, w_wbn, 3'b000});
        w_d       = w_px - w_sx;
        w_lo      = w_d[EW-1:3];
        w_hi      = w_lo + LW'(1);
        w_lo_ok   = !w_lo[LW-1] && (w_lo < LW'(w_wbn));
        w_hi_ok   = !w_hi[LW-1] && (w_hi < LW'(w_wbn));
        w_r       = w_y - r_y[r_k];
        w_rw      = {3'b000, w_r} * {{ROWS_W{1'b0}}, w_wbn};
        w_addr_lo = r_base[r_k] + {{(TEX_AW-ROWS_W-3){1'b0}}, w_rw}
                  + {{(TEX_AW-LW){w_lo[LW-1]}}, w_lo};
        w_pair    = {r_blo, (w_hi_ok ? dataT : 8'h00)} << w_d[2:0];
        w_bits    = w_pair[15:8];
        w_last    = (r_k == C_LAST);
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) r_state <= IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE:     if (req) w_next = CHECK;
            CHECK:    if (w_hit) w_next = FETCH_LO;
                      else if (w_last) w_next = DONE;
            FETCH_LO: w_next = FETCH_HI;
            FETCH_HI: w_next = MERGE;
            MERGE:    w_next = w_last ? DONE : CHECK;
            DONE:     w_next = IDLE;
            default:  w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            dataD    <= 8'h00;
            addrT    <= '0;
            r_addr_d <= '0;
            r_en     <= '0;
            r_inv    <= 1'b0;
            r_k      <= '0;
            r_acc    <= 8'h00;
            r_blo    <= 8'h00;
            for (int i = 0; i < NUM_SPR; i++) begin
                r_x[i]    <= '0;
                r_y[i]    <= '0;
                r_wb[i]   <= '0;
                r_h[i]    <= '0;
                r_base[i] <= '0;
            end
        end else begin
            done <= 1'b0;
            case (r_state)
                IDLE: if (req) begin
                    r_addr_d <= addrD;
                    r_en     <= spr_en;
                    r_inv    <= invert;
                    for (int i = 0; i < NUM_SPR; i++) begin
                        r_x[i]    <= spr_x[i*XW +: XW];
                        r_y[i]    <= spr_y[i*ROWS_W +: ROWS_W];
                        r_wb[i]   <= spr_wb[i*2 +: 2];
                        r_h[i]    <= spr_h[i*ROWS_W +: ROWS_W];
                        r_base[i] <= spr_base[i*TEX_AW +: TEX_AW];
                    end
                    busy  <= 1'b1;
                    r_k   <= '0;
                    r_acc <= 8'h00;
                end
                CHECK: begin
                    if (w_hit) addrT <= w_addr_lo;
                    else       r_k   <= r_k + KW'(1);
                end
                FETCH_LO: addrT <= w_addr_lo + TEX_AW'(1);
                FETCH_HI: r_blo <= w_lo_ok ? dataT : 8'h00;
                MERGE: begin
                    r_acc <= r_acc | w_bits;
                    r_k   <= r_k + KW'(1);
                end
                DONE: begin
                    dataD <= ((r_acc == 8'h00) ? BG_BYTE : r_acc) ^ {8{r_inv}};
                    done  <= 1'b1;
                    busy  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

`ifdef SPRITE_COLLIDE_EN
    logic [7:0] r_bits0;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_bits0 <= 8'h00;
            collide <= 1'b0;
        end else begin
            if (r_state == IDLE && req)
                r_bits0 <= 8'h00;
            else if (r_state == MERGE && r_k == '0)
                r_bits0 <= w_bits;
            if (clr_collide)
                collide <= 1'b0;
            else if (r_state == MERGE && r_k != '0 && (w_bits & r_bits0) != 8'h00)
                collide <= 1'b1;
        end
    end
`else
    logic w_unused_clr;
    assign w_unused_clr = clr_collide;
    assign collide      = 1'b0;
`endif

endmodule
`default_nettype wire

// File: doc/sprite_compositor.md
# sprite_compositor

Parametrised per-byte pixel compositor for the Rex Runner display path; the multi-sprite successor to the fixed dino/obstacle decider. For each byte request from the display driver, it walks a configurable number of sprite channels. Each channel has a pixel-accurate (non-byte-aligned) position and is fetched from the synchronous texture ROM. The block ORs all hits into one 8-pixel byte and returns it over a req/done handshake. It also flags dino/obstacle pixel collisions.

## Interface
- NUM_SPR, 3, number of sprite channels; channel 0 is the dino.
- COLS_W, 4, byte-column index width (screen width = 8·2^COLS_W px).
- ROWS_W, 6, row index width (screen height = 2^ROWS_W px).
- TEX_AW, 16, texture address width.
- BG_BYTE, 8'h00, byte returned where no sprite hits.

Ports:
- clk  in  1  system clock; one clock domain.
- rstn  in  1  asynchronous active-low reset.
- req  in  1  request strobe; addrD must be valid in the cycle req=1.
- addrD  in  COLS_W+ROWS_W  {col, row}; row 0 = top line.
- busy  out  1  request in progress.
- done  out  1  one-cycle pulse; dataD is valid from this cycle onward.
- dataD  out  8  composed byte; bit 7 = leftmost pixel; held until the next done.
- addrT  out  TEX_AW  texture address.
- dataT  in  8  texture byte, valid one cycle after addrT (sync ROM); bit 7 = leftmost.
- spr_en  in  NUM_SPR  channel enable.
- spr_x  in  NUM_SPR·(COLS_W+3)  left pixel x per channel.
- spr_y  in  NUM_SPR·ROWS_W  bottom-row y (y up, y = 2^ROWS_W-1-row).
- spr_wb  in  NUM_SPR·2  width in bytes minus 1 (1..4 bytes).
- spr_h  in  NUM_SPR·ROWS_W  height in rows; 0 = never hits.
- spr_base  in  NUM_SPR·TEX_AW  texture base; row 0 = bottom row, row-major, WB bytes per row.
- invert  in  1  night mode; output byte is inverted.
- clr_collide  in  1  synchronous clear of collide.
- collide  out  1  sticky collision flag.

## Operation
- States: IDLE, CHECK, FETCH_LO, FETCH_HI, MERGE, DONE.
- IDLE: when req=1, snapshot addrD, all spr_*, and invert. Set busy=1, k=0, acc=0, go to CHECK. A req while busy=1 is ignored.
- CHECK (channel k): compute the hit condition with no wrap (widths extended by 2 bits):
  - spr_en[k] is set;
  - y ≥ spr_y and y < spr_y+spr_h;
  - 8·col+7 ≥ spr_x and 8·col < spr_x+8·WB.
  - On a hit, go to FETCH_LO. Otherwise k++; go to DONE after k = NUM_SPR-1.
- Source index arithmetic: d = 8·col − spr_x (signed, COLS_W+5 bits); lo = d>>>3; sh = d[2:0]; r = y − spr_y.
- FETCH_LO: addrT = spr_base + r·WB + lo.
- FETCH_HI: addrT = spr_base + r·WB + lo+1; capture dataT as B_lo.
- MERGE: capture dataT as B_hi.
  - A byte whose index is < 0 or ≥ WB is forced to 0; addrT for it is don't-care.
  - bits = ({B_lo,B_hi} << sh)[15:8]; acc |= bits.
  - Then k++ and go to CHECK, or to DONE after the last channel.
- DONE: dataD = (acc==0 ? BG_BYTE : acc) ^ {8{invert}}; done=1; busy=0; return to IDLE.
- Collision: set when channel k≥1 bits & channel-0 bits ≠ 0 within one request. clr_collide takes priority over set in the same cycle.
- Reset values: dataD=8'h00, done=0, busy=0, addrT=0, collide=0, state=IDLE. Reset mid-request aborts the request with no done.

## Timing
- Per channel: 1 cycle on a miss, 4 cycles on a hit (CHECK, FETCH_LO, FETCH_HI, MERGE).
- done asserts NUM_SPR + 3·hits + 1 cycles after the accept edge. With NUM_SPR=3: no hits → 4 cycles; all hits → 13 cycles.
- Earliest next accept: the cycle after done (IDLE).
- Spr_* changes after accept do not affect the in-flight request.
- collide updates at the MERGE edge; it is visible no later than done.

## Configuration
- SPRITE_COLLIDE_EN:
  - Defined: collision logic as above.
  - Undefined: collide tied to 0, clr_collide ignored, channel-0 bit register removed. Composition and latency are unchanged.

## Test plan
- Aligned hit: ch0 x=8, y=10, wb=0, h=4, base=0x0100; ROM[0x0101]=8'hA5; other channels off; addrD={1,52} → dataD=8'hA5, done 7 cycles after accept.
- Unaligned: same setup but x=12 → addrD={1,52} gives 8'h0A, and addrD={2,52} gives 8'h50.
- Miss / background / night mode: addrD={0,0}, all miss, BG_BYTE=0 → dataD=8'h00 after 4 cycles; with invert=1 → 8'hFF.
- Collision: ch1 with the same placement as ch0 (ROM byte 8'hA5, aligned case) → collide=1 by done. Pulse clr_collide → collide=0 next cycle. Same cycle as a set → 0.
- Handshake and reset: a second req while busy is ignored (exactly one done). rstn low mid-FETCH_HI → busy=0, dataD=0, no done; the next req completes normally.
- Clipping: ch0 x=124, wb=1 → col 15 returns the left 4 bits of byte 0, with no wrap to col 0.
